// File: rtl/ippcrc_pkg.sv
// Shared types, mode encodings and the bit-serial CRC reference step used by
// the streaming CRC engine.
package ippcrc_pkg;

    localparam int unsigned CRC_MAX = 64;
    localparam int unsigned DAT_MAX = 512;

    localparam logic GEN = 1'b0;
    localparam logic CHK = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    // One LFSR shift: MSB-first register, result masked to crc_w bits.
    function automatic logic [CRC_MAX-1:0] crc_bit(
        input logic [CRC_MAX-1:0] crc,
        input logic               b,
        input logic [CRC_MAX-1:0] poly,
        input int unsigned        crc_w
    );
        logic [CRC_MAX-1:0] mask;
        logic               fb;
        mask = (crc_w >= CRC_MAX) ? '1 : ((CRC_MAX'(1) << crc_w) - CRC_MAX'(1));
        fb   = crc[6'(crc_w - 1)] ^ b;
        return ((crc << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

    // Applies dat[0] first, stopping after min(nbit, dat_w) bits.
    function automatic logic [CRC_MAX-1:0] crc_step(
        input logic [CRC_MAX-1:0] crc,
        input logic [DAT_MAX-1:0] dat,
        input int unsigned        nbit,
        input logic [CRC_MAX-1:0] poly,
        input int unsigned        crc_w,
        input int unsigned        dat_w
    );
        logic [CRC_MAX-1:0] c;
        c = crc;
        for (int unsigned i = 0; i < DAT_MAX; i++) begin
            if (i < dat_w && i < nbit) begin
                c = crc_bit(c, dat[9'(i)], poly, crc_w);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ippcrc_crc_stream_if.sv
// Word-stream bus into the CRC engine and its result/status signals.
interface ippcrc_crc_stream_if #(
    parameter int unsigned CRC_W = 12,
    parameter int unsigned DAT_W = 104
);
    localparam int unsigned NB_W = $clog2(DAT_W + 1);

    logic             i_vld;
    logic             i_sop;
    logic             i_eop;
    logic [NB_W-1:0]  i_nbit;
    logic [DAT_W-1:0] i_dat;
    logic             i_chk;
    logic             o_vld;
    logic [CRC_W-1:0] o_crc;
    logic             o_err;
    logic             o_seqerr;
    logic             o_busy;

    modport master (
        output i_vld, i_sop, i_eop, i_nbit, i_dat, i_chk,
        input  o_vld, o_crc, o_err, o_seqerr, o_busy
    );

    modport slave (
        input  i_vld, i_sop, i_eop, i_nbit, i_dat, i_chk,
        output o_vld, o_crc, o_err, o_seqerr, o_busy
    );
endinterface

// File: rtl/ippcrc_crc_step.sv
// Combinational single-cycle CRC update over up to DAT_W bits; bits at or
// beyond nbit leave the register untouched, so nbit > DAT_W clamps naturally.
module ippcrc_crc_step
    import ippcrc_pkg::*;
#(
    parameter int unsigned           CRC_W = 12,
    parameter logic [CRC_W-1:0]      POLY  = 12'h80F,
    parameter int unsigned           DAT_W = 104,
    localparam int unsigned          NB_W  = $clog2(DAT_W + 1)
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [DAT_W-1:0] dat,
    input  logic [NB_W-1:0]  nbit,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_MAX-1:0] full;

    always_comb begin
        full    = crc_step(CRC_MAX'(crc_in), DAT_MAX'(dat), 32'(nbit),
                           CRC_MAX'(POLY), CRC_W, DAT_W);
        crc_out = CRC_W'(full);
    end

endmodule

// File: rtl/ippcrc_crc_stream.sv
// Framed streaming CRC engine: IDLE/BUSY framing FSM, running CRC register
// and a one-cycle-latency result stage with generate/check modes.
module ippcrc_crc_stream
    import ippcrc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 12,
    parameter logic [CRC_W-1:0] POLY    = 12'h80F,
    parameter int unsigned      DAT_W   = 104,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter logic [CRC_W-1:0] CHK_RES = '0
) (
    input  logic                clk,
    input  logic                rst,
    ippcrc_crc_stream_if.slave  s
);

    localparam int unsigned NB_W = $clog2(DAT_W + 1);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             chk_q, chk_d;
    logic             vld_q, vld_d;
    logic [CRC_W-1:0] ocrc_q, ocrc_d;
    logic             err_q, err_d;
    logic             seqerr_q, seqerr_d;

    logic [CRC_W-1:0] seed;
    logic [NB_W-1:0]  step_nbit;
    logic [CRC_W-1:0] step_crc;
    logic             mode;

    ippcrc_crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .DAT_W (DAT_W)
    ) u_step (
        .crc_in  (seed),
        .dat     (s.i_dat),
        .nbit    (step_nbit),
        .crc_out (step_crc)
    );

    // A sop word always restarts from INIT, even when it aborts a frame in BUSY.
    always_comb begin
        seed      = s.i_sop ? INIT : crc_q;
        step_nbit = s.i_eop ? s.i_nbit : NB_W'(DAT_W);
        mode      = s.i_sop ? s.i_chk : chk_q;

        state_d  = state_q;
        crc_d    = crc_q;
        chk_d    = chk_q;
        vld_d    = 1'b0;
        ocrc_d   = ocrc_q;
        err_d    = err_q;
        seqerr_d = 1'b0;

        if (s.i_vld) begin
            if (s.i_sop || state_q == ST_BUSY) begin
                if (s.i_sop) begin
                    chk_d    = s.i_chk;
                    seqerr_d = (state_q == ST_BUSY);
                end
                if (s.i_eop) begin
                    vld_d   = 1'b1;
                    ocrc_d  = step_crc ^ XOROUT;
                    err_d   = (mode == CHK) && (step_crc != CHK_RES);
                    crc_d   = INIT;
                    state_d = ST_IDLE;
                end else begin
                    crc_d   = step_crc;
                    state_d = ST_BUSY;
                end
            end else begin
                seqerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            crc_q    <= INIT;
            chk_q    <= GEN;
            vld_q    <= 1'b0;
            ocrc_q   <= '0;
            err_q    <= 1'b0;
            seqerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            chk_q    <= chk_d;
            vld_q    <= vld_d;
            ocrc_q   <= ocrc_d;
            err_q    <= err_d;
            seqerr_q <= seqerr_d;
        end
    end

    assign s.o_vld    = vld_q;
    assign s.o_crc    = ocrc_q;
    assign s.o_err    = err_q;
    assign s.o_seqerr = seqerr_q;
    assign s.o_busy   = (state_q == ST_BUSY);

endmodule
